// File: rtl/sub_shft_div.sv
// Sequential restoring signed divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Truncates toward zero; shares the start/done handshake with the shift-add signed multiplier.
module sub_shft_div #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [2*N-1:0] a,
  input  logic signed [N-1:0]   b,
  input  logic                  start,
  output logic signed [N-1:0]   q,
  output logic signed [N-1:0]   r,
  output logic                  done,
  output logic                  dbz,
  output logic                  ovf
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    CNT_ONE  = 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
  localparam logic [2*N-1:0]   ONE_2N   = 1;
  localparam logic [N-1:0]     ONE_N    = 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state;
  logic            sa, sb, e_dbz, e_ovf;
  logic [N:0]      rem;
  logic [N-1:0]    quo, dvs;
  logic [CW-1:0]   cnt;

  logic [2*N-1:0]  a_mag;
  logic [N-1:0]    b_mag;
  logic            b_zero, pre_ovf;
  logic [N:0]      rem_sh;
  logic            fits;
  logic            neg_q, q_ovf;

  function automatic logic [2*N-1:0] abs_2n(input logic [2*N-1:0] x);
    return x[2*N-1] ? ((~x) + ONE_2N) : x;
  endfunction

  function automatic logic [N-1:0] abs_n(input logic [N-1:0] x);
    return x[N-1] ? ((~x) + ONE_N) : x;
  endfunction

  function automatic logic [N-1:0] apply_sign(input logic neg, input logic [N-1:0] mag);
    return neg ? ((~mag) + ONE_N) : mag;
  endfunction

  // Magnitude range of an N-bit signed result: +2^(N-1)-1 when positive, 2^(N-1) when negative.
  function automatic logic quo_sat(input logic neg, input logic [N-1:0] mag);
    return mag[N-1] & (~neg | (|mag[N-2:0]));
  endfunction

  assign a_mag   = abs_2n(a);
  assign b_mag   = abs_n(b);
  assign b_zero  = (b == '0);
  assign pre_ovf = (a_mag[2*N-1:N] >= b_mag);

  // Restoring step: shift {rem,quo} left, subtract the divisor when it fits.
  assign rem_sh  = {rem[N-1:0], quo[N-1]};
  assign fits    = (rem_sh >= {1'b0, dvs});
  assign neg_q   = sa ^ sb;
  assign q_ovf   = quo_sat(neg_q, quo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b1;
    end else if (start) begin
      done  <= 1'b0;
      sa    <= a[2*N-1];
      sb    <= b[N-1];
      rem   <= {1'b0, a_mag[2*N-1:N]};
      quo   <= a_mag[N-1:0];
      dvs   <= b_mag;
      cnt   <= '0;
      e_dbz <= b_zero;
      e_ovf <= ~b_zero & pre_ovf;
      state <= (b_zero || pre_ovf) ? FIX : CALC;
    end else begin
      case (state)
        CALC: begin
          rem <= fits ? (rem_sh - {1'b0, dvs}) : rem_sh;
          quo <= {quo[N-2:0], fits};
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= FIX;
        end
        // Result stage: early flags take priority, then the signed range check.
        FIX: begin
          if (e_dbz || e_ovf || q_ovf) begin
            q   <= '0;
            r   <= '0;
            dbz <= e_dbz;
            ovf <= ~e_dbz;
          end else begin
            q   <= apply_sign(neg_q, quo);
            r   <= apply_sign(sa, rem[N-1:0]);
            dbz <= 1'b0;
            ovf <= 1'b0;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sub_shft_div.md
Name: sub_shft_div

Overview:
- Sequential signed divider, one quotient bit per clock; the inverse of the team's shift-add signed multiplier.
- Divides a 2N-bit signed dividend by an N-bit signed divisor and returns an N-bit signed quotient and remainder.
- Division truncates toward zero, so the remainder takes the sign of the dividend.
- Uses the same start/done handshake as the multiplier so the two can share a controller.

Parameters:
- N, 8, divisor, quotient and remainder width. The dividend is 2N bits wide. N >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- a  input  2N  signed dividend, sampled only on the start edge
- b  input  N  signed divisor, sampled only on the start edge
- start  input  1  one-cycle request pulse
- q  output  N  signed quotient, registered
- r  output  N  signed remainder, registered
- done  output  1  high when idle and results are valid
- dbz  output  1  divide-by-zero flag for the last operation
- ovf  output  1  quotient-overflow flag for the last operation

Behaviour:
- Reset values: q=0, r=0, dbz=0, ovf=0, done=1, state IDLE. Reset wins over start.
- Reset mid-operation aborts immediately. No partial results are written.
- States: IDLE, CALC, FIX.
- Edge that samples start=1, from any state (restart is allowed mid-CALC or mid-FIX; new operands replace the old ones):
  - done <= 0.
  - Latch sa=a[2N-1], sb=b[N-1], A=|a| (2N-bit unsigned; |−2^(2N−1)| fits), B=|b| (N-bit unsigned).
  - Load the working register: R (N+1 bits) <= A[2N-1:N], Q <= A[N-1:0], counter <= 0.
  - If b==0: set the early flag E=dbz and go to FIX.
  - Else if A[2N-1:N] >= B (unsigned pre-overflow): set E=ovf and go to FIX.
  - Else go to CALC.
- CALC, one restoring step per edge:
  - Shift {R,Q} left by 1, giving R' (N+1 bits).
  - If R' >= B: R <= R' − B and Q[0] <= 1. Else R <= R' and Q[0] <= 0.
  - counter increments. After the Nth step (counter == N−1 on the edge) go to FIX.
- FIX (one edge), writes outputs and sets done <= 1, state IDLE:
  - Early dbz: q=0, r=0, dbz=1, ovf=0.
  - Early ovf: q=0, r=0, dbz=0, ovf=1.
  - Otherwise:
    - Quotient sign s = sa XOR sb.
    - Signed overflow if s=0 and Q > 2^(N−1)−1, or s=1 and Q > 2^(N−1). Then q=0, r=0, ovf=1, dbz=0.
    - Else q = s ? −Q : Q, r = sa ? −R[N-1:0] : R[N-1:0], dbz=0, ovf=0.
- The remainder always fits in N bits because |r| < |b| <= 2^(N−1).
- Latency, with the start edge as edge 0:
  - Normal operation: results and done=1 appear after edge N+1 (N=8: edge 9).
  - dbz or pre-overflow: results and done=1 appear after edge 1.
- q, r, dbz and ovf hold their previous values from the start edge until the FIX edge.
- In IDLE the outputs are stable and done stays 1 indefinitely.
- start while done=1 is the normal case. start=0 in IDLE means no action.
- Invariant on a valid result: a == q*b + r, with r==0 or sign(r)==sign(a).

Test Plan:
- Reset, then a=16'hE69C (−6500), b=8'h64 (100), start pulse:
  - done low from edge 0, high after edge 9.
  - q=8'hBF (−65), r=8'h00, dbz=0, ovf=0.
- a=16'hFF9C (−100), b=8'h07:
  - q=8'hF2 (−14), r=8'hFE (−2).
  - Repeat with b=8'hF9 (−7): q=8'h0E (14), r=8'hFE (−2).
- Overflow at the quotient boundary:
  - a=16'h4000 (16384), b=8'h80 (−128): q=8'h80 (−128), r=0, ovf=0.
  - a=16'hC000 (−16384), b=8'h80 (−128): signed ovf=1, q=0, r=0, done after edge 9.
- Early exits:
  - b=8'h00, a=16'h1234: dbz=1, ovf=0, q=0, r=0, done=1 after edge 1.
  - a=16'h7FFF, b=8'h01: pre-overflow ovf=1, done after edge 1.
- Restart and reset mid-operation:
  - Start −6500/100, then at edge 4 start again with a=16'h0064, b=8'h0A: q=8'h0A, r=0, done after edge 4+9. No intermediate done pulse.
  - Separately, assert rst during CALC: all outputs return to their reset values and done=1 on the next edge.
- Random sweep of 10,000 operand pairs against a truncating-division model:
  - Check q, r, dbz and ovf match the model.
  - Check the invariant a == q*b + r on every non-error result.
